// File: rtl/alu_packet_engine.sv
`default_nettype none
// ============================================================================
// Module   : alu_packet_engine
// Purpose  : Byte-stream packet engine for the UART ALU. It parses a 4-byte
//            header (opcode, reserved, LEN low, LEN high) and then either
//            echoes the payload byte for byte or sums the 32-bit
//            little-endian payload operands and returns the 4-byte sum.
//            Malformed or unknown packets are drained with a one-cycle
//            error pulse.
// Ports    : clk_i, reset_i (async, active-high)
//            s_axis_tdata/tvalid/tready : byte input from uart_rx
//            m_axis_tdata/tvalid/tready : byte output to uart_tx
//            busy_o : high whenever the engine is not waiting for an opcode
//            err_o  : one-cycle pulse on a malformed/unknown packet
// Revision : 1.0 - initial release
// ============================================================================
module alu_packet_engine #(
  parameter logic [7:0] OPCODE_ECHO = 8'hEC,
  parameter logic [7:0] OPCODE_ADD  = 8'h01
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    HDR_OP    = 3'd0,
    HDR_RSV   = 3'd1,
    HDR_LEN_L = 3'd2,
    HDR_LEN_H = 3'd3,
    ECHO      = 3'd4,
    ADD_RX    = 3'd5,
    ADD_TX    = 3'd6,
    DROP      = 3'd7
  } state_t;

  state_t      state_q,   state_d;
  logic [7:0]  opcode_q,  opcode_d;
  logic [7:0]  len_lo_q,  len_lo_d;
  logic [15:0] cnt_q,     cnt_d;
  logic [31:0] acc_q,     acc_d;
  logic [23:0] opbuf_q,   opbuf_d;
  logic [1:0]  tx_idx_q,  tx_idx_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q,  m_data_d;
  logic        err_q,     err_d;

  logic        s_ready;
  logic        s_fire;
  logic [15:0] len_full;
  logic [15:0] payload;
  logic [7:0]  tx_byte;

  assign len_full = {s_axis_tdata, len_lo_q};
  assign payload  = len_full - 16'd4;

  // Input ready depends on state; forced low while reset is held.
  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      HDR_OP:                        s_ready = !m_valid_q; // don't let a pending echo byte be overtaken
      HDR_RSV, HDR_LEN_L, HDR_LEN_H: s_ready = 1'b1;
      ECHO:                          s_ready = !m_valid_q || m_axis_tready;
      ADD_RX, DROP:                  s_ready = 1'b1;
      ADD_TX:                        s_ready = 1'b0;
      default:                       s_ready = 1'b0;
    endcase
  end

  assign s_axis_tready = s_ready && !reset_i;
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    tx_byte = acc_q[7:0];
    case (tx_idx_q)
      2'd0:    tx_byte = acc_q[7:0];
      2'd1:    tx_byte = acc_q[15:8];
      2'd2:    tx_byte = acc_q[23:16];
      default: tx_byte = acc_q[31:24];
    endcase
  end

  // The sum is streamed straight from the accumulator; echo bytes come from
  // the single output register. The two never overlap because ADD_TX is only
  // reachable through HDR_OP, which waits for the output register to empty.
  assign m_axis_tvalid = m_valid_q || (state_q == ADD_TX);
  assign m_axis_tdata  = (state_q == ADD_TX) ? tx_byte : m_data_q;
  assign busy_o        = (state_q != HDR_OP);
  assign err_o         = err_q;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    len_lo_d  = len_lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opbuf_d   = opbuf_q;
    tx_idx_d  = tx_idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    err_d     = 1'b0;

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      HDR_OP: begin
        if (s_fire) begin
          opcode_d = s_axis_tdata;
          state_d  = HDR_RSV;
        end
      end
      HDR_RSV: begin
        if (s_fire) state_d = HDR_LEN_L;
      end
      HDR_LEN_L: begin
        if (s_fire) begin
          len_lo_d = s_axis_tdata;
          state_d  = HDR_LEN_H;
        end
      end
      HDR_LEN_H: begin
        if (s_fire) begin
          cnt_d = payload;
          if (len_full < 16'd4) begin
            // Counter held at zero so a short LEN never appears as a huge payload.
            cnt_d   = 16'd0;
            err_d   = 1'b1;
            state_d = HDR_OP;
          end else if (opcode_q == OPCODE_ECHO) begin
            state_d = (payload == 16'd0) ? HDR_OP : ECHO;
          end else if (opcode_q == OPCODE_ADD && payload[1:0] != 2'd0) begin
            err_d   = 1'b1;
            state_d = (payload == 16'd0) ? HDR_OP : DROP;
          end else if (opcode_q == OPCODE_ADD) begin
            acc_d    = 32'd0;
            tx_idx_d = 2'd0;
            state_d  = (payload == 16'd0) ? ADD_TX : ADD_RX;
          end else begin
            err_d   = 1'b1;
            state_d = (payload == 16'd0) ? HDR_OP : DROP;
          end
        end
      end
      ECHO: begin
        if (s_fire) begin
          m_data_d  = s_axis_tdata;
          m_valid_d = 1'b1;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = HDR_OP;
        end
      end
      ADD_RX: begin
        if (s_fire) begin
          opbuf_d = {s_axis_tdata, opbuf_q[23:8]};
          cnt_d   = cnt_q - 16'd1;
          // Payload length is a multiple of 4, so the count's low bits mark
          // the operand byte position: a count of 1 mod 4 is the top byte.
          if (cnt_q[1:0] == 2'd1) begin
            acc_d = acc_q + {s_axis_tdata, opbuf_q};
          end
          if (cnt_q == 16'd1) state_d = ADD_TX;
        end
      end
      ADD_TX: begin
        if (m_axis_tready) begin
          tx_idx_d = tx_idx_q + 2'd1;
          if (tx_idx_q == 2'd3) state_d = HDR_OP;
        end
      end
      DROP: begin
        if (s_fire) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = HDR_OP;
        end
      end
      default: state_d = HDR_OP;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= HDR_OP;
      opcode_q  <= 8'd0;
      len_lo_q  <= 8'd0;
      cnt_q     <= 16'd0;
      acc_q     <= 32'd0;
      opbuf_q   <= 24'd0;
      tx_idx_q  <= 2'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      len_lo_q  <= len_lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opbuf_q   <= opbuf_d;
      tx_idx_q  <= tx_idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_packet_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_packet_engine
// Purpose  : Self-checking bench for alu_packet_engine. Expected output bytes
//            are pushed to a scoreboard queue as packets are sent and popped
//            whenever the DUT completes an output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_packet_engine;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       busy_o;
  logic       err_o;

  alu_packet_engine #(
    .OPCODE_ECHO(8'hEC),
    .OPCODE_ADD (8'h01)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          err_seen = 0;
  int          hold_ready = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] ops_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'd0;
  logic        smp_mvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, and score
  // the output handshake that will happen on the next rising edge.
  task automatic cycle(input logic sv, input logic [7:0] sd, output logic acc);
    logic mr;
    @(negedge clk);
    mr = (hold_ready == 0);
    if (hold_ready > 0) hold_ready--;
    s_axis_tvalid = sv;
    s_axis_tdata  = sd;
    m_axis_tready = mr;
    #1;
    acc = sv && s_axis_tready;
    if (err_o) err_seen++;
    if (prev_stall) begin
      chk("stall_valid_held", {31'd0, m_axis_tvalid}, 32'd1);
      chk("stall_data_stable", {24'd0, m_axis_tdata}, {24'd0, prev_data});
    end
    if (m_axis_tvalid && !mr) chk("bp_s_tready_low", {31'd0, s_axis_tready}, 32'd0);
    if (m_axis_tvalid && mr) begin
      chk("out_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) chk("out_byte", {24'd0, m_axis_tdata}, {24'd0, exp_q.pop_front()});
    end
    smp_mvalid = m_axis_tvalid;
    prev_stall = m_axis_tvalid && !mr;
    prev_data  = m_axis_tdata;
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) cycle(1'b1, b, acc);
    if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycle(1'b0, 8'h00, acc);
    chk("drain_empty", exp_q.size(), 32'd0);
    idle(3);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send(op);
    send(8'h00);
    send(len[7:0]);
    send(len[15:8]);
  endtask

  // Sends an add packet carrying ops_q and scores the modulo-2^32 sum.
  task automatic send_add(input logic check_lat);
    logic [31:0] sum;
    logic [31:0] op;
    int          n;
    sum = 32'd0;
    n   = ops_q.size();
    foreach (ops_q[i]) sum = sum + ops_q[i];
    for (int k = 0; k < 4; k++) exp_q.push_back(sum[8*k +: 8]);
    send_hdr(8'h01, 16'(4 + 4 * n));
    for (int i = 0; i < n; i++) begin
      op = ops_q[i];
      for (int k = 0; k < 4; k++) send(op[8*k +: 8]);
    end
    if (check_lat) begin
      idle(1);
      chk("add_latency_valid", {31'd0, smp_mvalid}, 32'd1);
    end
    ops_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i       = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tdata",  {24'd0, m_axis_tdata},  32'd0);
    chk("rst_busy",     {31'd0, busy_o},        32'd0);
    chk("rst_err",      {31'd0, err_o},         32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("post_rst_s_tready", {31'd0, s_axis_tready}, 32'd1);
    prev_stall = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int e0;
    int nops;
    reset_i       = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    m_axis_tready = 1'b1;
    do_reset();

    // Echo DE AD BE EF
    e0 = err_seen;
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    send_hdr(8'hEC, 16'h0008);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    drain();
    chk("echo_err", err_seen - e0, 32'd0);
    chk("echo_busy_idle", {31'd0, busy_o}, 32'd0);

    // Add 5 + 7, first result byte one cycle after the last payload byte
    ops_q.push_back(32'd5); ops_q.push_back(32'd7);
    send_add(1'b1);
    drain();

    // Wrap-around
    ops_q.push_back(32'hFFFF_FFFF); ops_q.push_back(32'h0000_0002);
    send_add(1'b1);
    drain();

    // Zero-operand add returns zero one cycle after the header
    send_add(1'b1);
    drain();

    // Zero-payload echo: nothing out, no error
    e0 = err_seen;
    send_hdr(8'hEC, 16'h0004);
    drain();
    chk("echo_empty_err", err_seen - e0, 32'd0);

    // LEN below the header size
    e0 = err_seen;
    send_hdr(8'hEC, 16'h0002);
    drain();
    chk("short_len_err", err_seen - e0, 32'd1);

    // Unknown opcode with 4 payload bytes
    e0 = err_seen;
    send_hdr(8'h55, 16'h0008);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    drain();
    chk("unknown_op_err", err_seen - e0, 32'd1);
    chk("unknown_op_idle", {31'd0, busy_o}, 32'd0);

    // Misaligned add, then a good add
    e0 = err_seen;
    send_hdr(8'h01, 16'h0007);
    send(8'h01); send(8'h02); send(8'h03);
    drain();
    chk("misaligned_add_err", err_seen - e0, 32'd1);
    ops_q.push_back(32'h1234_5678); ops_q.push_back(32'h0101_0101);
    send_add(1'b0);
    drain();

    // Echo with output backpressure
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    send_hdr(8'hEC, 16'h0008);
    send(8'hA1);
    hold_ready = 10;
    send(8'hB2); send(8'hC3); send(8'hD4);
    drain();

    // Add result with output backpressure
    ops_q.push_back(32'h89AB_CDEF); ops_q.push_back(32'h1111_1111);
    send_add(1'b0);
    hold_ready = 10;
    drain();

    // Reset after 6 bytes of an add packet
    e0 = err_seen;
    send(8'h01); send(8'h00); send(8'h0C); send(8'h00); send(8'h05); send(8'h00);
    do_reset();
    idle(5);
    chk("mid_rst_err", err_seen - e0, 32'd0);
    ops_q.push_back(32'd100); ops_q.push_back(32'd23);
    send_add(1'b1);
    drain();

    // Random add packets against a modulo-2^32 model
    for (int p = 0; p < 100; p++) begin
      nops = $urandom_range(2, 5);
      for (int i = 0; i < nops; i++) ops_q.push_back($urandom);
      send_add(1'b0);
      hold_ready = $urandom_range(0, 3);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
